// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decoder feeding a 2-entry skid FIFO
// between fetch and the register-file/execute stage.
module decode_stage #(
    parameter int XLEN      = 32,
    parameter bit EN_SYSTEM = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rs1_en,
    output logic            out_rs2_en,
    output logic            out_rd_en,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);
    localparam logic [1:0] S_EMPTY = 2'b00;
    localparam logic [1:0] S_ONE   = 2'b01;
    localparam logic [1:0] S_TWO   = 2'b11;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OPI   = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_MISC  = 7'b0001111;
    localparam logic [6:0] OPC_SYS   = 7'b1110011;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rs1_en;
        logic            rs2_en;
        logic            rd_en;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    logic [1:0] state;
    entry_t     slot0;
    entry_t     slot1;
    entry_t     dec;
    logic       push;
    logic       pop;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       i31;

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];
    assign i31 = in_instr[31];

    logic is_op, is_opi, is_load, is_jalr, is_store, is_br;
    logic is_lui, is_auipc, is_jal, is_misc, is_sys;

    assign is_op    = (opc == OPC_OP);
    assign is_opi   = (opc == OPC_OPI);
    assign is_load  = (opc == OPC_LOAD);
    assign is_jalr  = (opc == OPC_JALR);
    assign is_store = (opc == OPC_STORE);
    assign is_br    = (opc == OPC_BR);
    assign is_lui   = (opc == OPC_LUI);
    assign is_auipc = (opc == OPC_AUIPC);
    assign is_jal   = (opc == OPC_JAL);
    assign is_misc  = (opc == OPC_MISC);
    assign is_sys   = (opc == OPC_SYS);

    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{i31}}, in_instr[31:20]};
    assign imm_s = {{20{i31}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{i31}}, i31, in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{i31}}, i31, in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

    logic signed [31:0] imm32;
    logic               rs1_use;
    logic               rs2_use;
    logic               rd_use;
    logic               bad;

    always_comb begin
        dec        = '0;
        dec.pc     = in_pc;
        dec.opcode = opc;
        imm32      = '0;
        rs1_use    = 1'b0;
        rs2_use    = 1'b0;
        rd_use     = 1'b0;
        bad        = 1'b0;
        unique case (1'b1)
            is_op: begin
                dec.funct3 = f3;
                dec.funct7 = f7;
                dec.rs1    = in_instr[19:15];
                dec.rs2    = in_instr[24:20];
                dec.rd     = in_instr[11:7];
                rs1_use    = 1'b1;
                rs2_use    = 1'b1;
                rd_use     = 1'b1;
                bad = (f7 != 7'd0 && f7 != F7_ALT) ||
                      (f7 == F7_ALT && f3 != 3'b000 && f3 != 3'b101);
            end
            is_opi, is_load, is_jalr: begin
                dec.funct3 = f3;
                dec.rs1    = in_instr[19:15];
                dec.rd     = in_instr[11:7];
                rs1_use    = 1'b1;
                rd_use     = 1'b1;
                imm32      = imm_i;
                bad = (is_opi && f3 == 3'b001 && f7 != 7'd0) ||
                      (is_opi && f3 == 3'b101 &&
                       f7 != 7'd0 && f7 != F7_ALT) ||
                      (is_load && (f3 == 3'b011 || f3[2:1] == 2'b11)) ||
                      (is_jalr && f3 != 3'b000);
            end
            is_store, is_br: begin
                dec.funct3 = f3;
                dec.rs1    = in_instr[19:15];
                dec.rs2    = in_instr[24:20];
                rs1_use    = 1'b1;
                rs2_use    = 1'b1;
                imm32      = is_store ? imm_s : imm_b;
                bad = is_store ? (f3 >= 3'b011) : (f3[2:1] == 2'b01);
            end
            is_lui, is_auipc, is_jal: begin
                dec.rd = in_instr[11:7];
                rd_use = 1'b1;
                imm32  = is_jal ? imm_j : imm_u;
            end
            is_misc, is_sys: begin
                dec.funct3 = f3;
                dec.rs1    = in_instr[19:15];
                dec.rd     = in_instr[11:7];
                imm32      = is_sys ? imm_i : '0;
                bad        = (EN_SYSTEM == 1'b0);
            end
            default: bad = 1'b1;
        endcase
        if (in_instr[1:0] != 2'b11) bad = 1'b1;
        dec.illegal = bad;
        dec.imm     = XLEN'(imm32);
        dec.rs1_en  = rs1_use & ~bad;
        dec.rs2_en  = rs2_use & ~bad;
        dec.rd_en   = rd_use & ~bad & (in_instr[11:7] != 5'd0);
    end

    // Ready/valid come straight from state bits: no out_ready -> in_ready path.
    assign in_ready  = ~state[1];
    assign out_valid = state[0];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_EMPTY;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            state <= S_EMPTY;
        end else begin
            unique case (state)
                S_EMPTY: begin
                    if (push) begin
                        slot0 <= dec;
                        state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        slot0 <= dec;
                    end else if (push) begin
                        slot1 <= dec;
                        state <= S_TWO;
                    end else if (pop) begin
                        state <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (pop) begin
                        slot0 <= slot1;
                        state <= S_ONE;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

    assign out_pc      = slot0.pc;
    assign out_opcode  = slot0.opcode;
    assign out_funct3  = slot0.funct3;
    assign out_funct7  = slot0.funct7;
    assign out_rs1     = slot0.rs1;
    assign out_rs2     = slot0.rs2;
    assign out_rd      = slot0.rd;
    assign out_rs1_en  = slot0.rs1_en;
    assign out_rs2_en  = slot0.rs2_en;
    assign out_rd_en   = slot0.rd_en;
    assign out_imm     = slot0.imm;
    assign out_illegal = slot0.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage, two instances
// (system ops enabled / disabled) driven by the same stimulus.
module tb_decode_stage;
    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        e1;
        logic        e2;
        logic        ed;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    typedef struct packed {
        exp_t s;
        exp_t n;
    } pair_t;

    localparam logic [6:0] OPS [11] = '{7'h37, 7'h17, 7'h6F, 7'h67,
        7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        s_in_ready, s_out_valid, n_in_ready, n_out_valid;
    logic [31:0] s_pc, n_pc, s_imm, n_imm;
    logic [6:0]  s_opc, n_opc, s_f7, n_f7;
    logic [2:0]  s_f3, n_f3;
    logic [4:0]  s_rs1, n_rs1, s_rs2, n_rs2, s_rd, n_rd;
    logic        s_e1, n_e1, s_e2, n_e2, s_ed, n_ed, s_ill, n_ill;
    exp_t        s_act, n_act;

    int checks = 0;
    int errors = 0;
    pair_t q[$];

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .EN_SYSTEM(1'b1)) u_sys (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_pc(s_pc), .out_opcode(s_opc), .out_funct3(s_f3),
        .out_funct7(s_f7), .out_rs1(s_rs1), .out_rs2(s_rs2),
        .out_rd(s_rd), .out_rs1_en(s_e1), .out_rs2_en(s_e2),
        .out_rd_en(s_ed), .out_imm(s_imm), .out_illegal(s_ill)
    );

    decode_stage #(.XLEN(32), .EN_SYSTEM(1'b0)) u_nos (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(n_out_valid), .out_ready(out_ready),
        .out_pc(n_pc), .out_opcode(n_opc), .out_funct3(n_f3),
        .out_funct7(n_f7), .out_rs1(n_rs1), .out_rs2(n_rs2),
        .out_rd(n_rd), .out_rs1_en(n_e1), .out_rs2_en(n_e2),
        .out_rd_en(n_ed), .out_imm(n_imm), .out_illegal(n_ill)
    );

    assign s_act = {s_pc, s_opc, s_f3, s_f7, s_rs1, s_rs2, s_rd,
                    s_e1, s_e2, s_ed, s_imm, s_ill};
    assign n_act = {n_pc, n_opc, n_f3, n_f7, n_rs1, n_rs2, n_rd,
                    n_e1, n_e2, n_ed, n_imm, n_ill};

    // Reference decode written from the ISA field tables.
    function automatic exp_t model(input logic [31:0] i,
                                   input logic [31:0] pc, input bit sys);
        exp_t e;
        int   si;
        int   imm;
        bit   r1, r2, wr, bad;
        logic [2:0] f3;
        logic [6:0] f7;
        e = '0; si = i; imm = 0;
        r1 = 0; r2 = 0; wr = 0; bad = 0;
        f3 = i[14:12]; f7 = i[31:25];
        e.pc = pc; e.opcode = i[6:0];
        case (i[6:0])
            7'h33: begin
                e.f3 = f3; e.f7 = f7; e.rs1 = i[19:15];
                e.rs2 = i[24:20]; e.rd = i[11:7];
                r1 = 1; r2 = 1; wr = 1;
                bad = !(f7 inside {7'h00, 7'h20}) ||
                      (f7 == 7'h20 && !(f3 inside {3'd0, 3'd5}));
            end
            7'h13, 7'h03, 7'h67: begin
                e.f3 = f3; e.rs1 = i[19:15]; e.rd = i[11:7];
                r1 = 1; wr = 1; imm = si >>> 20;
                if (i[6:0] == 7'h13)
                    bad = (f3 == 1 && f7 != 0) ||
                          (f3 == 5 && !(f7 inside {7'h00, 7'h20}));
                else if (i[6:0] == 7'h03)
                    bad = f3 inside {3'd3, 3'd6, 3'd7};
                else
                    bad = (f3 != 0);
            end
            7'h23: begin
                e.f3 = f3; e.rs1 = i[19:15]; e.rs2 = i[24:20];
                r1 = 1; r2 = 1;
                imm = (si >>> 25) * 32 + int'(i[11:7]);
                bad = (f3 >= 3);
            end
            7'h63: begin
                e.f3 = f3; e.rs1 = i[19:15]; e.rs2 = i[24:20];
                r1 = 1; r2 = 1;
                imm = (si >>> 31) * 4096 + int'(i[7]) * 2048 +
                      int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
                bad = f3 inside {3'd2, 3'd3};
            end
            7'h37, 7'h17: begin
                e.rd = i[11:7]; wr = 1; imm = si & 32'hFFFFF000;
            end
            7'h6F: begin
                e.rd = i[11:7]; wr = 1;
                imm = (si >>> 31) * (1 << 20) + int'(i[19:12]) * 4096 +
                      int'(i[20]) * 2048 + int'(i[30:21]) * 2;
            end
            7'h0F, 7'h73: begin
                e.f3 = f3; e.rs1 = i[19:15]; e.rd = i[11:7];
                if (i[6:0] == 7'h73) imm = si >>> 20;
                bad = !sys;
            end
            default: bad = 1;
        endcase
        if (i[1:0] != 2'b11) bad = 1;
        e.imm = imm;
        e.ill = bad;
        e.e1 = r1 && !bad;
        e.e2 = r2 && !bad;
        e.ed = wr && !bad && (i[11:7] != 0);
        return e;
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] i;
        int sel;
        i = $urandom;
        sel = $urandom_range(0, 13);
        if (sel < 11) i[6:0] = OPS[sel];
        if ($urandom_range(0, 3) != 0)
            i[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return i;
    endfunction

    task automatic chk_e(input string nm, input exp_t a, input exp_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, a, e);
        end
    endtask

    task automatic chk_v(input string nm, input logic [31:0] a,
                         input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, a, e);
        end
    endtask

    // Monitor: pops on every handshake, records every accepted push.
    always @(negedge clk) begin
        pair_t p;
        if (rst) begin
            q.delete();
        end else begin
            if (s_out_valid || n_out_valid)
                chk_v("valid_match", 32'(n_out_valid), 32'(s_out_valid));
            if (s_out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out got pc=%h exp=none",
                             s_pc);
                end else begin
                    p = q.pop_front();
                    chk_e("entry_sys", s_act, p.s);
                    chk_e("entry_nosys", n_act, p.n);
                end
            end
            if (flush) q.delete();
            else if (in_valid && s_in_ready) begin
                p.s = model(in_instr, in_pc, 1'b1);
                p.n = model(in_instr, in_pc, 1'b0);
                q.push_back(p);
            end
        end
    end

    task automatic drive(input logic [31:0] i, input logic [31:0] pc);
        bit acc;
        int n;
        acc = 0; n = 0;
        in_valid = 1; in_instr = i; in_pc = pc;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = s_in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 0;
        chk_v("accept_timeout", 32'(acc), 32'd1);
    endtask

    initial begin
        bit acc;
        rst = 1; flush = 0; in_valid = 1; out_ready = 0;
        in_instr = 32'h0020A423; in_pc = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        rst = 0; in_valid = 0;
        @(negedge clk);
        chk_e("rst_out_sys", s_act, '0);
        chk_e("rst_out_nosys", n_act, '0);
        chk_v("rst_valid", 32'(s_out_valid), 0);
        chk_v("rst_ready", 32'(s_in_ready), 1);

        out_ready = 1;
        drive(32'hFFF00093, 32'h100);
        @(negedge clk);
        chk_v("lat1_valid", 32'(s_out_valid), 1);
        chk_v("addi_imm", s_imm, 32'hFFFFFFFF);
        chk_v("addi_rd", 32'(s_rd), 1);
        chk_v("addi_rd_en", 32'(s_ed), 1);
        drive(32'h0020A423, 32'h104);
        drive(32'hFE000EE3, 32'h108);
        drive(32'h00000000, 32'h10C);
        drive(32'h40001033, 32'h110);
        drive(32'h00000073, 32'h114);
        @(negedge clk);
        chk_v("ecall_nosys_ill", 32'(n_ill), 1);
        chk_v("ecall_sys_ill", 32'(s_ill), 0);
        @(posedge clk);
        #1;

        // back-pressure: two accepted, third held upstream
        out_ready = 0;
        drive(32'h00100113, 32'h200);
        drive(32'h00208193, 32'h204);
        in_valid = 1; in_instr = 32'h00310213; in_pc = 32'h208;
        @(negedge clk);
        chk_v("bp_in_ready", 32'(s_in_ready), 0);
        chk_v("bp_out_valid", 32'(s_out_valid), 1);
        @(posedge clk);
        #1;
        out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_v("bp_stream", 32'(s_out_valid), 1);
            acc = s_in_ready;
            @(posedge clk);
            #1;
            if (acc) in_valid = 0;
        end
        repeat (2) @(posedge clk);
        #1;

        // flush while full with a push pending
        out_ready = 0;
        drive(32'h00400293, 32'h300);
        drive(32'h00500313, 32'h304);
        in_valid = 1; in_instr = 32'h00600393; in_pc = 32'h308;
        flush = 1;
        @(posedge clk);
        #1;
        flush = 0; in_valid = 0;
        @(negedge clk);
        chk_v("flush_valid", 32'(s_out_valid), 0);
        chk_v("flush_ready", 32'(s_in_ready), 1);
        out_ready = 1;
        repeat (3) @(posedge clk);
        #1;

        // reset while full with a push pending
        out_ready = 0;
        drive(32'h00700413, 32'h400);
        drive(32'h00800493, 32'h404);
        in_valid = 1; in_instr = 32'h00900513; in_pc = 32'h408;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0; in_valid = 0;
        @(negedge clk);
        chk_e("rst2_out", s_act, '0);
        chk_v("rst2_valid", 32'(s_out_valid), 0);
        chk_v("rst2_ready", 32'(s_in_ready), 1);
        out_ready = 1;
        drive(32'h00A00593, 32'h40C);
        @(negedge clk);
        chk_v("rst2_lat1", 32'(s_out_valid), 1);
        @(posedge clk);
        #1;

        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            in_instr  = gen();
            in_pc     = $urandom & 32'hFFFFFFFC;
            @(posedge clk);
            #1;
        end

        in_valid = 0; flush = 0; out_ready = 1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_v("drain_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32I instruction decode stage that replaces the combinational `DecoderEnable`-gated decoder. It sits between the fetch stage and the register-file/execute stage. It accepts one instruction per cycle over a valid/ready handshake and buffers up to two decoded entries in a skid FIFO, so back-pressure never drops an instruction. For each instruction it extracts register fields, produces per-field use enables and a sign-extended immediate, and flags illegal encodings.

## Interface
Parameters:
- `XLEN`, default 32: width of PC and immediate. Legal values are 32 and 64.
- `EN_SYSTEM`, default 1: when 1, MISC_MEM (0001111) and SYSTEM (1110011) decode as legal; when 0 they are flagged illegal.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `flush`, input, 1: synchronous discard of all buffered entries.
- `in_valid`, input, 1: upstream holds a valid instruction.
- `in_ready`, output, 1: stage can accept an instruction this cycle.
- `in_instr`, input, 32: raw instruction word.
- `in_pc`, input, XLEN: PC of `in_instr`.
- `out_valid`, output, 1: head entry is valid.
- `out_ready`, input, 1: downstream consumes the head this cycle.
- `out_pc`, output, XLEN: PC of the head entry.
- `out_opcode`, output, 7: head entry opcode field.
- `out_funct3`, output, 3: head entry funct3 field.
- `out_funct7`, output, 7: head entry funct7 field.
- `out_rs1`, output, 5: head entry rs1 field.
- `out_rs2`, output, 5: head entry rs2 field.
- `out_rd`, output, 5: head entry rd field.
- `out_rs1_en`, output, 1: head entry reads rs1.
- `out_rs2_en`, output, 1: head entry reads rs2.
- `out_rd_en`, output, 1: head entry writes a register (rd ≠ 0).
- `out_imm`, output, XLEN: head entry immediate, sign-extended to XLEN.
- `out_illegal`, output, 1: head entry is an illegal encoding.

## Operation
- Decode is combinational on `in_instr`. The result is written into a 2-entry FIFO (slot 0 is the head and drives `out_*`; slot 1 is the skid slot). Occupancy states: EMPTY, ONE, TWO.
- Push = `in_valid & in_ready`. Pop = `out_valid & out_ready`.
- State transitions:
  - EMPTY → ONE on push.
  - ONE → EMPTY on pop without push.
  - ONE → ONE on push and pop together; the new entry becomes the head.
  - ONE → TWO on push without pop.
  - TWO → ONE on pop; slot 1 moves to slot 0.
  - No push is possible in TWO.
- Fields per opcode. Any field not used by the opcode is driven as 0, never Z.
  - OP: rs1, rs2, rd, funct3, funct7. `rs1_en = rs2_en = 1`.
  - OP_IMM, LOAD, JALR: rs1, rd, funct3. `rs1_en = 1`.
  - STORE, BRANCH: rs1, rs2, funct3. `rs1_en = rs2_en = 1`. rd = 0.
  - LUI, AUIPC, JAL: rd only.
  - MISC_MEM, SYSTEM: funct3, rs1, rd fields are passed through; all enables are 0.
- `out_rd_en = 1` only when the opcode writes rd and rd ≠ 0.
- Immediate by format, always sign-extended from `instr[31]` to XLEN:
  - I-type (OP_IMM, LOAD, JALR, SYSTEM): `instr[31:20]`.
  - S-type (STORE): `{[31:25],[11:7]}`.
  - B-type (BRANCH): `{[31],[7],[30:25],[11:8],0}`.
  - U-type (LUI, AUIPC): `{[31:12],12'b0}`.
  - J-type (JAL): `{[31],[19:12],[20],[30:21],0}`.
  - All other opcodes: 0.
- `out_illegal = 1` for any of:
  - `instr[1:0] ≠ 11`
  - an unknown opcode
  - OP with funct7 ∉ {0000000, 0100000}
  - OP with funct7 = 0100000 and funct3 ∉ {000, 101}
  - OP_IMM funct3 = 001 with `[31:25] ≠ 0`
  - OP_IMM funct3 = 101 with `[31:25] ∉ {0000000, 0100000}`
  - JALR with funct3 ≠ 000
  - BRANCH with funct3 ∈ {010, 011}
  - LOAD with funct3 ∈ {011, 110, 111}
  - STORE with funct3 ≥ 011
  - MISC_MEM or SYSTEM when `EN_SYSTEM = 0`
- When `out_illegal = 1`, all enables are forced to 0. The remaining fields are still presented.

## Timing
- Latency: an instruction pushed in cycle N appears at `out_*` with `out_valid = 1` in cycle N+1 when the FIFO was EMPTY, or when it was ONE and popped in cycle N.
- Throughput: 1 instruction per cycle while `out_ready = 1`.
- `in_ready = (state ≠ TWO)`, a function of registered state only. There is no combinational path from `out_ready` to `in_ready`.
- `out_*` are driven from registers only. Outputs are stable while `out_valid & ~out_ready`.
- `flush`: the next state is EMPTY, and any push in the same cycle is discarded. In the next cycle `out_valid = 0` and `in_ready = 1`. `flush` takes effect regardless of `out_ready`.
- `rst`: the next state is EMPTY and all `out_*` registers are cleared to 0, including `out_valid` and `out_illegal`. `in_ready` is 1 from the first cycle after reset. `rst` has priority over `flush`, push and pop. Asserting `rst` mid-stream drops both entries.
- Extension for `XLEN = 64`: `out_pc` is a pass-through; `out_imm` bits [63:32] replicate `instr[31]`.

## Test plan
- Push `0xFFF00093` (addi x1,x0,-1) at pc `0x100`, `out_ready = 1` → next cycle `out_valid = 1`, `opcode = 0010011`, `rd = 1`, `rs1 = 0`, `imm = 0xFFFFFFFF`, `rs1_en = 1`, `rs2_en = 0`, `rd_en = 1`, `illegal = 0`, `pc = 0x100`.
- Push `0x0020A423` (sw x2,8(x1)) → `imm = 8`, `rs1 = 1`, `rs2 = 2`, `rd = 0`, `rd_en = 0`. Push `0xFE000EE3` (beq x0,x0,-4) → `imm = 0xFFFFFFFC`, `funct3 = 000`.
- Push `0x00000000`, then `0x40001033`, then `0x00000073` with `EN_SYSTEM = 0` → `out_illegal = 1` for each, with all enables = 0.
- Hold `out_ready = 0`, push 3 back-to-back instructions → the first two are accepted, `in_ready = 0` from the cycle after the second push, and the third is held upstream. Release `out_ready` → the three instructions emerge in order, one per cycle.
- Fill to TWO, assert `flush` together with `in_valid = 1` → next cycle `out_valid = 0`, `in_ready = 1`, and the flushed instruction never appears.
- Assert `rst` while in TWO with `in_valid = 1` → next cycle all `out_*` = 0 and `in_ready = 1`. A new push after reset appears with latency 1.
